homography_responder: RTL and testbench



---
 rtl/homography_responder_pkg.sv | 33 +++
 rtl/homography_responder_affine_map.sv | 41 ++++
 rtl/homography_responder.sv | 113 +++++++++++
 tb/tb_homography_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/homography_responder_pkg.sv
// homography_responder_pkg: shared widths, identity coefficients and pipeline record types
package homography_responder_pkg;
  localparam int PIX_W   = 10;
  localparam int ADDR_W  = 19;
  localparam int COEF_W  = 16;
  localparam int TRANS_W = 18;
  localparam int FRAC    = 8;
  localparam int PROD_W  = COEF_W + PIX_W + 1;
  localparam int SUM_W   = PROD_W + 1;
  localparam int RES_W   = SUM_W - FRAC;
  localparam int R_LSB   = 11;
  localparam int G_LSB   = 5;
  localparam int B_LSB   = 0;
  localparam int R_W     = 5;
  localparam int G_W     = 6;
  localparam int B_W     = 5;
  typedef struct packed {
    logic signed [COEF_W-1:0]  a;
    logic signed [COEF_W-1:0]  b;
    logic signed [COEF_W-1:0]  c;
    logic signed [COEF_W-1:0]  d;
    logic signed [TRANS_W-1:0] tx;
    logic signed [TRANS_W-1:0] ty;
  } coef_t;
  localparam coef_t COEF_ID = '{a: 16'sh0100, b: '0, c: '0, d: 16'sh0100, tx: '0, ty: '0};
  // One entry of the sideband delay line that shadows the datapath
  typedef struct packed {
    logic             vld;
    logic [PIX_W-1:0] x;
    logic [PIX_W-1:0] y;
    logic             inb;
  } side_t;
endpackage

// File: rtl/homography_responder_affine_map.sv
// affine_map: registered products, then combinational sum, round and bounds test
module affine_map
  import homography_responder_pkg::*;
#(
  parameter int SRC_W = 640,
  parameter int SRC_H = 480
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  coef_t                   coef_i,
  input  logic [PIX_W-1:0]        x_i,
  input  logic [PIX_W-1:0]        y_i,
  output logic signed [RES_W-1:0] u_o,
  output logic signed [RES_W-1:0] v_o,
  output logic                    inb_o
);
  logic signed [PIX_W:0]   xs, ys;
  logic signed [PROD_W-1:0] ax_q, by_q, cx_q, dy_q;
  logic signed [TRANS_W-1:0] tx_q, ty_q;
  logic signed [SUM_W-1:0]  su, sv;
  assign xs = $signed({1'b0, x_i});
  assign ys = $signed({1'b0, y_i});
  // Stage 1: products and translation sampled together so a later coefficient load cannot tear a query
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      {ax_q, by_q, cx_q, dy_q} <= '0;
      {tx_q, ty_q} <= '0;
    end else begin
      ax_q <= PROD_W'($signed(coef_i.a)) * PROD_W'(xs);
      by_q <= PROD_W'($signed(coef_i.b)) * PROD_W'(ys);
      cx_q <= PROD_W'($signed(coef_i.c)) * PROD_W'(xs);
      dy_q <= PROD_W'($signed(coef_i.d)) * PROD_W'(ys);
      tx_q <= $signed(coef_i.tx);
      ty_q <= $signed(coef_i.ty);
    end
  assign su    = SUM_W'(ax_q) + SUM_W'(by_q) + SUM_W'(tx_q) + SUM_W'(1 << (FRAC - 1));
  assign sv    = SUM_W'(cx_q) + SUM_W'(dy_q) + SUM_W'(ty_q) + SUM_W'(1 << (FRAC - 1));
  assign u_o   = su[SUM_W-1:FRAC];
  assign v_o   = sv[SUM_W-1:FRAC];
  assign inb_o = !u_o[RES_W-1] && !v_o[RES_W-1] && (u_o < RES_W'(SRC_W)) && (v_o < RES_W'(SRC_H));
endmodule

// File: rtl/homography_responder.sv
// homography_responder: warps a query coordinate, fetches the RGB565 source pixel, returns it in order
module homography_responder
  import homography_responder_pkg::*;
#(
  parameter int SRC_W   = 640,
  parameter int SRC_H   = 480,
  parameter int MEM_LAT = 1
) (
  input  logic               clk_25,
  input  logic               rst,
  input  logic               start,
  input  logic [PIX_W-1:0]   query_x,
  input  logic [PIX_W-1:0]   query_y,
  input  logic               coef_we,
  input  logic [COEF_W-1:0]  coef_a,
  input  logic [COEF_W-1:0]  coef_b,
  input  logic [COEF_W-1:0]  coef_c,
  input  logic [COEF_W-1:0]  coef_d,
  input  logic [TRANS_W-1:0] coef_tx,
  input  logic [TRANS_W-1:0] coef_ty,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [15:0]        mem_rdata,
  output logic               ready,
  output logic [PIX_W-1:0]   return_x,
  output logic [PIX_W-1:0]   return_y,
  output logic [R_W-1:0]     r,
  output logic [G_W-1:0]     g,
  output logic [B_W-1:0]     b,
  output logic               busy
);
  localparam int DEPTH = MEM_LAT + 2;
  coef_t                   coef_q;
  side_t                   sb_q [DEPTH];
  logic signed [RES_W-1:0] u_c, v_c;
  logic                    inb_c;
  logic [ADDR_W-1:0]       u_a, v_a, addr_d;
  logic                    mem_rd_q;
  logic [ADDR_W-1:0]       mem_addr_q;
  logic                    ready_q;
  logic [PIX_W-1:0]        ret_x_q, ret_y_q;
  logic [R_W-1:0]          r_q;
  logic [G_W-1:0]          g_q;
  logic [B_W-1:0]          b_q;
  logic [15:0]             pix_d;
  logic                    busy_d;
  // Coefficient bank; a load takes effect for queries starting the cycle after
  always_ff @(posedge clk_25 or posedge rst)
    if (rst) coef_q <= COEF_ID;
    else if (coef_we) coef_q <= '{a: coef_a, b: coef_b, c: coef_c, d: coef_d, tx: coef_tx, ty: coef_ty};
  affine_map #(.SRC_W(SRC_W), .SRC_H(SRC_H)) u_map (
    .clk_i (clk_25),
    .rst_i (rst),
    .coef_i(coef_q),
    .x_i   (query_x),
    .y_i   (query_y),
    .u_o   (u_c),
    .v_o   (v_c),
    .inb_o (inb_c)
  );
  assign u_a    = ADDR_W'(u_c[PIX_W-1:0]);
  assign v_a    = ADDR_W'(v_c[PIX_W-1:0]);
  assign addr_d = (SRC_W == 640) ? (v_a << 9) + (v_a << 7) + u_a : v_a * ADDR_W'(SRC_W) + u_a;
  // Sideband delay line: coordinate and valid enter with start, bounds flag joins after the warp
  always_ff @(posedge clk_25 or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sb_q[i] <= '0;
    end else begin
      sb_q[0] <= '{vld: start, x: query_x, y: query_y, inb: 1'b0};
      sb_q[1] <= '{vld: sb_q[0].vld, x: sb_q[0].x, y: sb_q[0].y, inb: inb_c};
      for (int i = 2; i < DEPTH; i++) sb_q[i] <= sb_q[i-1];
    end
  // Read request; the address holds across idle and out-of-bounds cycles
  always_ff @(posedge clk_25 or posedge rst)
    if (rst) begin
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      mem_rd_q <= sb_q[0].vld && inb_c;
      if (sb_q[0].vld && inb_c) mem_addr_q <= addr_d;
    end
  assign pix_d = sb_q[DEPTH-1].inb ? mem_rdata : 16'h0000;
  // Result register: captures read data alongside the echoed coordinate, holds when idle
  always_ff @(posedge clk_25 or posedge rst)
    if (rst) begin
      ready_q <= 1'b0;
      {ret_x_q, ret_y_q} <= '0;
      {r_q, g_q, b_q} <= '0;
    end else begin
      ready_q <= sb_q[DEPTH-1].vld;
      if (sb_q[DEPTH-1].vld) begin
        ret_x_q <= sb_q[DEPTH-1].x;
        ret_y_q <= sb_q[DEPTH-1].y;
        r_q     <= pix_d[R_LSB +: R_W];
        g_q     <= pix_d[G_LSB +: G_W];
        b_q     <= pix_d[B_LSB +: B_W];
      end
    end
  // Busy while any query is anywhere in the delay line
  always_comb begin
    busy_d = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy_d = busy_d | sb_q[i].vld;
  end
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign ready    = ready_q;
  assign return_x = ret_x_q;
  assign return_y = ret_y_q;
  assign r        = r_q;
  assign g        = g_q;
  assign b        = b_q;
  assign busy     = busy_d;
endmodule

// File: tb/tb_homography_responder.sv
// tb_homography_responder: directed queries against a scoreboard of hand-computed results
module tb_homography_responder;
  logic        clk_25 = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  query_x = '0, query_y = '0;
  logic        coef_we = 1'b0;
  logic [15:0] coef_a = 16'h0100, coef_b = '0, coef_c = '0, coef_d = 16'h0100;
  logic [17:0] coef_tx = '0, coef_ty = '0;
  logic        mem_rd;
  logic [18:0] mem_addr;
  logic [15:0] mem_rdata = 16'hDEAD;
  logic        ready;
  logic [9:0]  return_x, return_y;
  logic [4:0]  r, b;
  logic [5:0]  g;
  logic        busy;
  int          cyc = 0;
  int          n_vec = 0, n_err = 0;
  logic        mem_pend = 1'b0;
  logic [18:0] mem_pa = '0;
  typedef struct {int cyc; logic [9:0] x; logic [9:0] y; logic [15:0] pix;} exp_t;
  typedef struct {int cyc; logic [18:0] addr;} mexp_t;
  exp_t  exp_q[$];
  mexp_t mem_q[$];

  homography_responder dut (
    .clk_25(clk_25), .rst(rst), .start(start), .query_x(query_x), .query_y(query_y),
    .coef_we(coef_we), .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c), .coef_d(coef_d),
    .coef_tx(coef_tx), .coef_ty(coef_ty), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .ready(ready), .return_x(return_x), .return_y(return_y),
    .r(r), .g(g), .b(b), .busy(busy)
  );

  always #20 clk_25 = ~clk_25;
  always @(posedge clk_25) cyc <= cyc + 1;

  function automatic logic [15:0] pix(input int a);
    return (a == 32100) ? 16'hF81F : (16'(a) ^ 16'h5A5A);
  endfunction

  // SRAM model with one cycle of read latency
  always @(negedge clk_25) begin
    mem_pend = mem_rd;
    mem_pa   = mem_addr;
  end
  initial forever begin
    @(posedge clk_25);
    #1 mem_rdata = mem_pend ? pix(int'(mem_pa)) : 16'hDEAD;
  end

  // Result monitor
  always @(negedge clk_25) begin : mon_ready
    exp_t e;
    if (!rst) begin
      if (ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_ready cyc=%0d got xy=(%0d,%0d)", cyc, return_x, return_y);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.cyc || return_x != e.x || return_y != e.y || {r, g, b} != e.pix) begin
            n_err++;
            $display("FAIL ready_result got cyc=%0d xy=(%0d,%0d) rgb=%h expected cyc=%0d xy=(%0d,%0d) rgb=%h",
                     cyc, return_x, return_y, {r, g, b}, e.cyc, e.x, e.y, e.pix);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL missing_ready cyc=%0d got ready=0 expected ready=1 xy=(%0d,%0d)", cyc, exp_q[0].x, exp_q[0].y);
        void'(exp_q.pop_front());
      end
    end
  end

  // Memory request monitor
  always @(negedge clk_25) begin : mon_mem
    mexp_t m;
    if (!rst) begin
      if (mem_rd) begin
        n_vec++;
        if (mem_q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_mem_rd cyc=%0d got addr=%0d", cyc, mem_addr);
        end else begin
          m = mem_q.pop_front();
          if (cyc != m.cyc || mem_addr != m.addr) begin
            n_err++;
            $display("FAIL mem_req got cyc=%0d addr=%0d expected cyc=%0d addr=%0d", cyc, mem_addr, m.cyc, m.addr);
          end
        end
      end else if (mem_q.size() != 0 && mem_q[0].cyc <= cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL missing_mem_rd cyc=%0d got mem_rd=0 expected addr=%0d", cyc, mem_q[0].addr);
        void'(mem_q.pop_front());
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  // Called #1 after a rising edge; holds start for exactly that cycle
  task automatic issue(input int x, input int y, input int addr, input bit track);
    start   = 1'b1;
    query_x = 10'(x);
    query_y = 10'(y);
    if (track) begin
      exp_q.push_back('{cyc: cyc + 4, x: 10'(x), y: 10'(y), pix: (addr < 0) ? 16'h0000 : pix(addr)});
      if (addr >= 0) mem_q.push_back('{cyc: cyc + 2, addr: 19'(addr)});
    end
    @(posedge clk_25);
    #1 start = 1'b0;
  endtask

  task automatic set_coef(input logic [15:0] a, bb, c, d, input logic [17:0] tx, ty);
    {coef_a, coef_b, coef_c, coef_d, coef_tx, coef_ty} = {a, bb, c, d, tx, ty};
    coef_we = 1'b1;
    @(posedge clk_25);
    #1 coef_we = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (exp_q.size() != 0 || mem_q.size() != 0); i++) @(posedge clk_25);
    @(posedge clk_25);
    #1 check("drain_pending", exp_q.size() + mem_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, int'(ready), 0);
    check({tag, "_mem_rd"}, int'(mem_rd), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_mem_addr"}, int'(mem_addr), 0);
    check({tag, "_return_x"}, int'(return_x), 0);
    check({tag, "_return_y"}, int'(return_y), 0);
    check({tag, "_rgb"}, int'({r, g, b}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_25);
    @(negedge clk_25);
    check_idle_outputs("reset");
    @(posedge clk_25);
    #1 rst = 1'b0;
    issue(100, 50, 32100, 1);
    drain();
    set_coef(16'h0100, 16'h0000, 16'h0000, 16'h0100, 18'h00A00, 18'h00000);
    issue(635, 0, -1, 1);
    drain();
    set_coef(16'h0080, 16'h0000, 16'h0000, 16'h0080, 18'h00000, 18'h00000);
    issue(3, 3, 1282, 1);
    drain();
    set_coef(16'h0100, 16'h0000, 16'h0000, 16'h0100, 18'h00000, 18'h00000);
    for (int i = 0; i < 480; i++) issue(i, 0, i, 1);
    drain();
    coef_a  = 16'h0200;
    coef_d  = 16'h0200;
    coef_we = 1'b1;
    issue(10, 10, 6410, 1);
    coef_we = 1'b0;
    issue(10, 10, 12820, 1);
    drain();
    issue(5, 5, 0, 0);
    issue(6, 6, 0, 0);
    start   = 1'b1;
    query_x = 10'd7;
    query_y = 10'd7;
    rst     = 1'b1;
    @(posedge clk_25);
    #1 start = 1'b0;
    @(negedge clk_25);
    check_idle_outputs("midrst");
    @(posedge clk_25);
    #1 rst = 1'b0;
    issue(1, 2, 1281, 1);
    repeat (8) @(posedge clk_25);
    #1 check("post_busy", int'(busy), 0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
